// File: rtl/float_mult_arbiter.sv
// Round-robin arbiter sharing one fixed-latency float multiplier among NUM_REQ requesters,
// with burst locking and an ID tag pipe that routes each result back to its owner.
module float_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 3,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [32*NUM_REQ-1:0] req_op_a,
    input  logic [32*NUM_REQ-1:0] req_op_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  mul_valid,
    output logic                  mul_last,
    output logic [31:0]           mul_op_a,
    output logic [31:0]           mul_op_b,
    input  logic                  mul_res_valid,
    input  logic                  mul_res_last,
    input  logic [31:0]           mul_result,
    input  logic [1:0]            mul_flow,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic                  rsp_last,
    output logic [31:0]           rsp_result,
    output logic [1:0]            rsp_flow,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy,
    output logic                  err_align
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     owner;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     issue_id;
    logic                any_win;
    logic                win_last;
    logic [MUL_LAT-1:0]  tag_vld;
    logic [MUL_LAT-1:0]  tag_last;
    logic [ID_W-1:0]     tag_id [MUL_LAT];
    logic                tail_vld;
    logic                tail_last;
    logic [ID_W-1:0]     tail_id;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base,
                                                 input logic [ID_W:0]   off);
        logic [ID_W:0] s;
        s = {1'b0, base} + off;
        if (s >= (ID_W+1)'(NUM_REQ))
            s = s - (ID_W+1)'(NUM_REQ);
        return s[ID_W-1:0];
    endfunction

    // Grant: scan downward so the candidate closest to ptr is the last one written.
    always_comb begin
        win_id  = owner;
        any_win = 1'b0;
        cand    = '0;
        if (!hold) begin
            if (state == LOCKED) begin
                any_win = req_valid[owner];
            end else begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    cand = wrap_inc(ptr, (ID_W+1)'(k));
                    if (req_valid[cand]) begin
                        win_id  = cand;
                        any_win = 1'b1;
                    end
                end
            end
        end
    end

    assign req_ready = any_win ? (NUM_REQ'(1) << win_id) : '0;
    assign win_last  = req_last[win_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else if (any_win) begin
            if (win_last) begin
                state <= IDLE;
                ptr   <= wrap_inc(win_id, (ID_W+1)'(1));
            end else begin
                state <= LOCKED;
                owner <= win_id;
            end
        end
    end

    // Issue stage: operands hold their last value when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid <= 1'b0;
            mul_last  <= 1'b0;
            mul_op_a  <= '0;
            mul_op_b  <= '0;
            issue_id  <= '0;
        end else begin
            mul_valid <= any_win;
            if (any_win) begin
                mul_last <= win_last;
                mul_op_a <= req_op_a[32*win_id +: 32];
                mul_op_b <= req_op_b[32*win_id +: 32];
                issue_id <= win_id;
            end
        end
    end

    // Tag pipe is fed from the issue register so its tail lines up with mul_res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld  <= '0;
            tag_last <= '0;
            for (int i = 0; i < MUL_LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_vld[0]  <= mul_valid;
            tag_last[0] <= mul_last;
            tag_id[0]   <= issue_id;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_last[i] <= tag_last[i-1];
                tag_id[i]   <= tag_id[i-1];
            end
        end
    end

    assign tail_vld  = tag_vld[MUL_LAT-1];
    assign tail_last = tag_last[MUL_LAT-1];
    assign tail_id   = tag_id[MUL_LAT-1];

    // Return stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_last   <= 1'b0;
            rsp_result <= '0;
            rsp_flow   <= '0;
            rsp_id     <= '0;
            err_align  <= 1'b0;
        end else begin
            if (tail_vld && mul_res_valid) begin
                rsp_valid  <= NUM_REQ'(1) << tail_id;
                rsp_id     <= tail_id;
                rsp_last   <= mul_res_last;
                rsp_result <= mul_result;
                rsp_flow   <= mul_flow;
            end else begin
                rsp_valid  <= '0;
            end
            if ((tail_vld != mul_res_valid) ||
                (tail_vld && mul_res_valid && (tail_last != mul_res_last)))
                err_align <= 1'b1;
        end
    end

    assign busy = (state == LOCKED) | mul_valid | (|tag_vld) | (|rsp_valid);

endmodule

// File: tb/tb_float_mult_arbiter.sv
// Bench for float_mult_arbiter: behavioural multiplier stand-in, transaction-level scoreboard,
// a table of single-beat products and directed multi-cycle sequences.
module tb_float_mult_arbiter;
    localparam int NUM_REQ = 4;
    localparam int MUL_LAT = 3;
    localparam int ID_W    = 2;
    localparam int LAT     = MUL_LAT + 2;

    logic                  clk, rst_n, hold, inject;
    logic [NUM_REQ-1:0]    req_valid, req_last, req_ready, rsp_valid;
    logic [32*NUM_REQ-1:0] req_op_a, req_op_b;
    logic                  mul_valid, mul_last, mul_res_valid, mul_res_last;
    logic [31:0]           mul_op_a, mul_op_b, mul_result, rsp_result;
    logic [1:0]            mul_flow, rsp_flow;
    logic                  rsp_last, busy, err_align;
    logic [ID_W-1:0]       rsp_id;

    float_mult_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid), .req_last(req_last),
        .req_op_a(req_op_a), .req_op_b(req_op_b), .req_ready(req_ready),
        .mul_valid(mul_valid), .mul_last(mul_last), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
        .mul_res_valid(mul_res_valid), .mul_res_last(mul_res_last), .mul_result(mul_result),
        .mul_flow(mul_flow), .rsp_valid(rsp_valid), .rsp_last(rsp_last),
        .rsp_result(rsp_result), .rsp_flow(rsp_flow), .rsp_id(rsp_id), .busy(busy),
        .err_align(err_align));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating single-precision multiply for normal operands; returns {flow, result}.
    function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {2'b00, s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin m = p[46:24]; e++; end
        else m = p[45:23];
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (e <= 0) return {2'b01, s, 31'd0};
        return {2'b00, s, e[7:0], m};
    endfunction

    logic        m_v [MUL_LAT];
    logic        m_l [MUL_LAT];
    logic [33:0] m_r [MUL_LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin m_v[i] <= 1'b0; m_l[i] <= 1'b0; m_r[i] <= '0; end
        end else begin
            m_v[0] <= mul_valid;
            m_l[0] <= mul_last;
            m_r[0] <= fmul(mul_op_a, mul_op_b);
            for (int i = 1; i < MUL_LAT; i++) begin
                m_v[i] <= m_v[i-1]; m_l[i] <= m_l[i-1]; m_r[i] <= m_r[i-1];
            end
        end
    end

    assign mul_res_valid = m_v[MUL_LAT-1] | inject;
    assign mul_res_last  = m_l[MUL_LAT-1];
    assign mul_result    = m_r[MUL_LAT-1][31:0];
    assign mul_flow      = m_r[MUL_LAT-1][33:32];

    typedef struct {
        int          due;
        int          id;
        logic        last;
        logic [33:0] res;
    } exp_t;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [1:0]  flow;
    } vec_t;

    exp_t q[$];
    int   m_ptr, m_owner, cyc, n_checks, n_fail;
    bit   m_locked, chk_en;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        e = 8'($urandom_range(40, 220));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Scoreboard step for the current cycle, called at the falling edge.
    task automatic model_check();
        int win;
        bit eb;
        logic [NUM_REQ-1:0] er;
        eb = m_locked;
        foreach (q[i]) if (cyc >= q[i].due - (LAT - 1) && cyc <= q[i].due) eb = 1'b1;
        check("busy", 64'(busy), 64'(eb));
        er = '0;
        if (q.size() > 0 && q[0].due == cyc) er = NUM_REQ'(1) << q[0].id;
        check("rsp_valid", 64'(rsp_valid), 64'(er));
        if (er != '0) begin
            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
            check("rsp_result", 64'(rsp_result), 64'(q[0].res[31:0]));
            check("rsp_flow", 64'(rsp_flow), 64'(q[0].res[33:32]));
            check("rsp_last", 64'(rsp_last), 64'(q[0].last));
            void'(q.pop_front());
        end
        win = -1;
        if (!hold) begin
            if (m_locked) begin
                if (req_valid[m_owner]) win = m_owner;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int r;
                    r = (m_ptr + k) % NUM_REQ;
                    if (win < 0 && req_valid[r]) win = r;
                end
            end
        end
        check("req_ready", 64'(req_ready), (win < 0) ? 64'd0 : (64'd1 << win));
        if (win >= 0) begin
            q.push_back('{cyc + LAT, win, req_last[win],
                          fmul(req_op_a[32*win +: 32], req_op_b[32*win +: 32])});
            if (req_last[win]) begin m_locked = 1'b0; m_ptr = (win + 1) % NUM_REQ; end
            else begin m_locked = 1'b1; m_owner = win; end
        end
    endtask

    task automatic end_cyc();
        if (chk_en) model_check();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic drive(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] l, input logic h);
        req_valid = v;
        req_last  = l;
        hold      = h;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_op_a[32*i +: 32] = rand_op();
            req_op_b[32*i +: 32] = rand_op();
        end
    endtask

    task automatic run_cyc(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] l,
                           input logic h, input logic [NUM_REQ-1:0] rdy, input int mv,
                           input string nm);
        drive(v, l, h);
        @(negedge clk);
        check({nm, "_ready"}, 64'(req_ready), 64'(rdy));
        if (mv >= 0) check({nm, "_mul_valid"}, 64'(mul_valid), 64'(mv));
        end_cyc();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive('0, '0, 1'b0);
            @(negedge clk);
            end_cyc();
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        inject = 1'b0;
        drive('0, '0, 1'b0);
        repeat (2) begin @(posedge clk); #1; cyc++; end
        @(negedge clk);
        check("reset_ctl", 64'({req_ready, mul_valid, mul_last, rsp_valid, rsp_last, rsp_flow,
                                rsp_id, busy, err_align}), 64'd0);
        check("reset_mul_ops", {mul_op_a, mul_op_b}, 64'd0);
        check("reset_rsp_result", 64'(rsp_result), 64'd0);
        q.delete();
        m_ptr = 0; m_owner = 0; m_locked = 1'b0;
        @(posedge clk); #1;
        cyc++;
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        bit   found;
        vt[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000, 2'b00};
        vt[1] = '{3, 32'h7F000000, 32'h7F000000, 32'h7F800000, 2'b10};
        vt[2] = '{1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 2'b00};
        vt[3] = '{2, 32'hC0000000, 32'h40000000, 32'hC0800000, 2'b00};
        vt[4] = '{1, 32'h00800000, 32'h00800000, 32'h00000000, 2'b01};
        vt[5] = '{2, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 2'b00};

        rst_n = 1'b0; hold = 1'b0; inject = 1'b0; chk_en = 1'b0;
        req_valid = '0; req_last = '0; req_op_a = '0; req_op_b = '0;
        cyc = 0; n_checks = 0; n_fail = 0;
        do_reset();

        foreach (vt[v]) begin
            drive('0, '0, 1'b0);
            req_valid[vt[v].idx] = 1'b1;
            req_last[vt[v].idx]  = 1'b1;
            req_op_a[32*vt[v].idx +: 32] = vt[v].a;
            req_op_b[32*vt[v].idx +: 32] = vt[v].b;
            @(negedge clk);
            check("tbl_ready", 64'(req_ready), 64'd1 << vt[v].idx);
            end_cyc();
            found = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                drive('0, '0, 1'b0);
                @(negedge clk);
                if (!found && rsp_valid != '0) begin
                    found = 1'b1;
                    check("tbl_latency", 64'(k), 64'(LAT));
                    check("tbl_rsp_valid", 64'(rsp_valid), 64'd1 << vt[v].idx);
                    check("tbl_result", 64'(rsp_result), 64'(vt[v].res));
                    check("tbl_flow", 64'(rsp_flow), 64'(vt[v].flow));
                    check("tbl_id", 64'(rsp_id), 64'(vt[v].idx));
                end
                end_cyc();
            end
            check("tbl_rsp_seen", 64'(found), 64'd1);
        end

        do_reset();
        for (int k = 0; k < 8; k++)
            run_cyc(4'hF, 4'hF, 1'b0, 4'(1 << (k % 4)), (k > 0) ? 1 : 0, "rr");
        drain(8);

        do_reset();
        run_cyc(4'b0110, 4'b0000, 1'b0, 4'b0010, -1, "lock");
        run_cyc(4'b0110, 4'b0000, 1'b0, 4'b0010, -1, "lock");
        run_cyc(4'b0100, 4'b0000, 1'b0, 4'b0000, -1, "lock_drop");
        run_cyc(4'b0110, 4'b0010, 1'b0, 4'b0010, -1, "lock");
        run_cyc(4'b0110, 4'b0100, 1'b0, 4'b0100, -1, "lock_ptr");
        run_cyc(4'b0110, 4'b0110, 1'b0, 4'b0010, -1, "lock_wrap");
        drain(8);

        do_reset();
        run_cyc(4'b0011, 4'b0000, 1'b0, 4'b0001, 0, "hold");
        run_cyc(4'b0011, 4'b0000, 1'b1, 4'b0000, 1, "hold");
        run_cyc(4'b0011, 4'b0000, 1'b1, 4'b0000, 0, "hold");
        run_cyc(4'b0011, 4'b0000, 1'b0, 4'b0001, 0, "hold");
        run_cyc(4'b0011, 4'b0001, 1'b0, 4'b0001, 1, "hold");
        run_cyc(4'b0011, 4'b0011, 1'b0, 4'b0010, 1, "hold");
        drain(8);

        do_reset();
        for (int k = 0; k < 3; k++) run_cyc(4'b0001, 4'b0000, 1'b0, 4'b0001, -1, "pre_rst");
        do_reset();
        run_cyc(4'b0010, 4'b0010, 1'b0, 4'b0010, 0, "post_rst");
        drain(8);

        do_reset();
        for (int k = 0; k < 400; k++) begin
            drive(4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0));
            @(negedge clk);
            end_cyc();
        end
        drain(10);
        check("rand_drained", 64'(q.size()), 64'd0);

        do_reset();
        chk_en = 1'b0;
        inject = 1'b1;
        @(negedge clk);
        end_cyc();
        inject = 1'b0;
        @(negedge clk);
        check("align_err", 64'(err_align), 64'd1);
        check("align_no_rsp", 64'(rsp_valid), 64'd0);
        end_cyc();
        repeat (3) begin @(negedge clk); end_cyc(); end
        @(negedge clk);
        check("align_sticky", 64'(err_align), 64'd1);
        end_cyc();
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
